// File: rtl/fwd_hazard_unit.sv
// D-stage hazard detection and operand forwarding over the E/M/W producer records.
// FWD_WB_BYPASS_EN: when defined, a ready W-stage producer is forwarded (sel=1); otherwise the GRF write-through covers it.
module fwd_hazard_unit #(
    parameter int DATA_W    = 32,
    parameter int NUM_PORTS = 2,
    parameter int TNEW_W    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        d_wr_en,
    input  logic [4:0]                  d_wr_addr,
    input  logic [TNEW_W-1:0]           d_tnew,
    input  logic                        flush,
    input  logic [NUM_PORTS*5-1:0]      rd_addr,
    input  logic [NUM_PORTS*TNEW_W-1:0] rd_tuse,
    input  logic [NUM_PORTS*DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0]           e_data,
    input  logic [DATA_W-1:0]           m_data,
    input  logic [DATA_W-1:0]           w_data,
    output logic                        stall,
    output logic [NUM_PORTS*2-1:0]      fwd_sel,
    output logic [NUM_PORTS*DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        addr;
        logic [TNEW_W-1:0] tnew;
    } rec_t;

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_W  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_E  = 2'd3;

`ifdef FWD_WB_BYPASS_EN
    localparam logic [1:0] W_HIT_SEL = SEL_W;
`else
    localparam logic [1:0] W_HIT_SEL = SEL_RF;
`endif

    rec_t e_q;
    rec_t m_q;
    rec_t w_q;

    logic [NUM_PORTS-1:0] port_stall;

    function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // M and W always advance so a stall drains on its own; only E takes the bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= {m_q.valid, m_q.addr, age_tnew(m_q.tnew)};
            m_q <= {e_q.valid, e_q.addr, age_tnew(e_q.tnew)};
            if (stall || flush) begin
                e_q <= '0;
            end else begin
                e_q <= {d_wr_en && (d_wr_addr != 5'd0), d_wr_addr, d_tnew};
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic [4:0]        addr;
        logic [TNEW_W-1:0] tuse;
        logic              hit;
        logic [TNEW_W-1:0] hit_tnew;
        logic [1:0]        hit_sel;
        logic              p_stall;
        logic [1:0]        p_sel;
        logic [DATA_W-1:0] p_data;

        assign addr = rd_addr[5*gi +: 5];
        assign tuse = rd_tuse[TNEW_W*gi +: TNEW_W];

        // Nearest producer wins; older matches are shadowed.
        always_comb begin
            hit      = 1'b0;
            hit_tnew = '0;
            hit_sel  = SEL_RF;
            if (addr != 5'd0) begin
                if (e_q.valid && (e_q.addr == addr)) begin
                    hit      = 1'b1;
                    hit_tnew = e_q.tnew;
                    hit_sel  = SEL_E;
                end else if (m_q.valid && (m_q.addr == addr)) begin
                    hit      = 1'b1;
                    hit_tnew = m_q.tnew;
                    hit_sel  = SEL_M;
                end else if (w_q.valid && (w_q.addr == addr)) begin
                    hit      = 1'b1;
                    hit_tnew = w_q.tnew;
                    hit_sel  = W_HIT_SEL;
                end
            end
        end

        // A producer that is not ready yet but will be by Tuse is left to the later-stage muxes.
        always_comb begin
            p_stall = 1'b0;
            p_sel   = SEL_RF;
            if (hit) begin
                if (hit_tnew > tuse) begin
                    p_stall = 1'b1;
                end else if (hit_tnew == '0) begin
                    p_sel = hit_sel;
                end
            end
        end

        always_comb begin
            case (p_sel)
                SEL_E:   p_data = e_data;
                SEL_M:   p_data = m_data;
                SEL_W:   p_data = w_data;
                default: p_data = rf_data[DATA_W*gi +: DATA_W];
            endcase
        end

        assign port_stall[gi]               = p_stall;
        assign fwd_sel[2*gi +: 2]           = p_sel;
        assign fwd_data[DATA_W*gi +: DATA_W] = p_data;
    end

    assign stall = |port_stall;

endmodule
